// File: rtl/srec_dump.sv
// srec_dump -- streams a memory region out as Motorola S-record text.
//
// A dump is started by a one-cycle start pulse in IDLE. The region
// [base_address, base_address+length) is read one byte at a time over a
// simple read port. It is emitted as S3 records of up to 16 data bytes each,
// followed by an S7 terminator record. Every record ends with a 0x0A line
// feed.
//
// Optional feature: define SREC_HEADER_EN to emit the fixed header record
// "S0030000FC\n" at the start of every dump.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   start                  pulse, sampled in IDLE only
//   base_address, length   dump region, latched on the accepted start
//   mem_address, mem_rd    byte read request, one-cycle strobe
//   mem_data_in            read data, valid the cycle after mem_rd
//   char_out, char_valid   ASCII character stream (source side)
//   char_ready             sink ready
//   busy                   dump in progress
//   done                   one-cycle pulse after the final newline is taken
//   dbg_state              current FSM state encoding, for observation
//
// Character handshake: a character transfers on a rising edge where
// char_valid and char_ready are both high. Once char_valid is raised, it and
// char_out stay unchanged until that transfer. After each transfer, the FSM
// spends one cycle with char_valid low while it loads the next character.
module srec_dump (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_address,
  input  logic [15:0] length,
  output logic [31:0] mem_address,
  output logic        mem_rd,
  input  logic [7:0]  mem_data_in,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        busy,
  output logic        done,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
`ifdef SREC_HEADER_EN
    HDR   = 4'd1,
`endif
    REC_S = 4'd2,
    REC_T = 4'd3,
    COUNT = 4'd4,
    ADDR  = 4'd5,
    FETCH = 4'd6,
    WAIT  = 4'd7,
    DATA  = 4'd8,
    CSUM  = 4'd9,
    EOL   = 4'd10,
    TERM  = 4'd11,
    DONE  = 4'd12
  } state_e;

  state_e      state_q;
  logic [31:0] base_q;
  logic [15:0] len_q;
  logic [15:0] off_q;        // offset of the next byte to fetch
  logic [4:0]  rec_n_q;      // data bytes in the current record
  logic [4:0]  rec_left_q;   // data bytes still to fetch in this record
  logic [31:0] rec_addr_q;
  logic [7:0]  csum_q;
  logic [7:0]  data_q;
  logic [3:0]  idx_q;        // character index within the current field
  logic [7:0]  char_out_q;
  logic        char_valid_q;
  logic [31:0] mem_addr_q;
  logic        mem_rd_q;
  logic        busy_q;
  logic        done_q;

  // Combinational helpers
  logic [15:0] remain_d;
  logic [4:0]  rec_n_d;
  logic [31:0] fetch_addr_d;
  logic [7:0]  count_byte;
  logic [7:0]  addr_sum;
  logic [7:0]  term_csum;
  logic [7:0]  emit_char;
  logic        emit_last;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Nibble i of a 32-bit word, i = 0 being the most significant.
  function automatic logic [3:0] nibble_of(input logic [31:0] w, input logic [2:0] i);
    return 4'(w >> {~i, 2'b00});
  endfunction

  function automatic logic [7:0] byte_sum(input logic [31:0] w);
    return w[31:24] + w[23:16] + w[15:8] + w[7:0];
  endfunction

`ifdef SREC_HEADER_EN
  function automatic logic [7:0] hdr_char(input logic [3:0] i);
    logic [7:0] c;
    case (i)
      4'd0:    c = "S";
      4'd1:    c = "0";
      4'd2:    c = "0";
      4'd3:    c = "3";
      4'd4:    c = "0";
      4'd5:    c = "0";
      4'd6:    c = "0";
      4'd7:    c = "0";
      4'd8:    c = "F";
      4'd9:    c = "C";
      default: c = 8'h0A;
    endcase
    return c;
  endfunction
`endif

  assign remain_d     = len_q - off_q;
  assign rec_n_d      = (remain_d > 16'd16) ? 5'd16 : remain_d[4:0];
  // 32-bit add wraps modulo 2^32, so a record may run through 0xFFFFFFFF.
  assign fetch_addr_d = base_q + {16'h0000, off_q};
  assign count_byte   = {3'b000, rec_n_q} + 8'd5;
  assign addr_sum     = byte_sum(rec_addr_q);
  assign term_csum    = ~(8'h05 + byte_sum(base_q));

  // Character that the current state emits at position idx_q, and whether
  // it is the last character of that state's field.
  always_comb begin
    emit_char = 8'h00;
    emit_last = 1'b0;
    case (state_q)
`ifdef SREC_HEADER_EN
      HDR: begin
        emit_char = hdr_char(idx_q);
        emit_last = (idx_q == 4'd10);
      end
`endif
      REC_S: begin
        emit_char = "S";
        emit_last = 1'b1;
      end
      REC_T: begin
        emit_char = "3";
        emit_last = 1'b1;
      end
      COUNT: begin
        emit_char = hex_ascii(idx_q[0] ? count_byte[3:0] : count_byte[7:4]);
        emit_last = idx_q[0];
      end
      ADDR: begin
        emit_char = hex_ascii(nibble_of(rec_addr_q, idx_q[2:0]));
        emit_last = (idx_q == 4'd7);
      end
      DATA: begin
        emit_char = hex_ascii(idx_q[0] ? data_q[3:0] : data_q[7:4]);
        emit_last = idx_q[0];
      end
      CSUM: begin
        emit_char = hex_ascii(idx_q[0] ? ~csum_q[3:0] : ~csum_q[7:4]);
        emit_last = idx_q[0];
      end
      EOL: begin
        emit_char = 8'h0A;
        emit_last = 1'b1;
      end
      TERM: begin
        // "S705" + 8 address digits + 2 checksum digits + LF
        if (idx_q == 4'd0)       emit_char = "S";
        else if (idx_q == 4'd1)  emit_char = "7";
        else if (idx_q == 4'd2)  emit_char = "0";
        else if (idx_q == 4'd3)  emit_char = "5";
        else if (idx_q <= 4'd11) emit_char = hex_ascii(nibble_of(base_q, idx_q[2:0] - 3'd4));
        else if (idx_q == 4'd12) emit_char = hex_ascii(term_csum[7:4]);
        else if (idx_q == 4'd13) emit_char = hex_ascii(term_csum[3:0]);
        else                     emit_char = 8'h0A;
        emit_last = (idx_q == 4'd14);
      end
      default: begin
        emit_char = 8'h00;
        emit_last = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      len_q        <= '0;
      off_q        <= '0;
      rec_n_q      <= '0;
      rec_left_q   <= '0;
      rec_addr_q   <= '0;
      csum_q       <= '0;
      data_q       <= '0;
      idx_q        <= '0;
      char_out_q   <= '0;
      char_valid_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // mem_rd is raised only on entry to FETCH, which lasts one cycle.
      mem_rd_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q <= base_address;
            len_q  <= length;
            off_q  <= '0;
            idx_q  <= '0;
            busy_q <= 1'b1;
`ifdef SREC_HEADER_EN
            state_q <= HDR;
`else
            state_q <= (length == 16'd0) ? TERM : REC_S;
`endif
          end
        end
        FETCH: state_q <= WAIT;
        WAIT: begin
          data_q     <= mem_data_in;
          csum_q     <= csum_q + mem_data_in;
          off_q      <= off_q + 16'd1;
          rec_left_q <= rec_left_q - 5'd1;
          state_q    <= DATA;
        end
        DONE: state_q <= IDLE;
        default: begin
          // Character-emitting states: load, wait for the transfer, advance.
          if (state_q == REC_S) csum_q <= '0;
          if (!char_valid_q) begin
            char_out_q   <= emit_char;
            char_valid_q <= 1'b1;
          end else if (char_ready) begin
            char_valid_q <= 1'b0;
            idx_q        <= idx_q + 4'd1;
            if (emit_last) begin
              idx_q <= '0;
              case (state_q)
`ifdef SREC_HEADER_EN
                HDR: state_q <= (len_q == 16'd0) ? TERM : REC_S;
`endif
                REC_S: begin
                  rec_n_q    <= rec_n_d;
                  rec_left_q <= rec_n_d;
                  rec_addr_q <= fetch_addr_d;
                  state_q    <= REC_T;
                end
                REC_T: state_q <= COUNT;
                COUNT: begin
                  csum_q  <= csum_q + count_byte;
                  state_q <= ADDR;
                end
                ADDR: begin
                  csum_q     <= csum_q + addr_sum;
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= fetch_addr_d;
                  state_q    <= FETCH;
                end
                DATA: begin
                  if (rec_left_q != 5'd0) begin
                    mem_rd_q   <= 1'b1;
                    mem_addr_q <= fetch_addr_d;
                    state_q    <= FETCH;
                  end else begin
                    state_q <= CSUM;
                  end
                end
                CSUM: state_q <= EOL;
                EOL:  state_q <= (off_q == len_q) ? TERM : REC_S;
                TERM: begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
                end
                default: state_q <= IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign mem_address = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign char_out    = char_out_q;
  assign char_valid  = char_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_srec_dump.sv
// Directed testbench for srec_dump. It runs a sequence of dumps. Each
// dump's character stream is collected and compared byte by byte against
// an expected queue. That queue comes from hand-written literals or from a
// small S-record formatter model.
module tb_srec_dump;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_DATA = 4'd8;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_address;
  logic [15:0] length;
  logic [31:0] mem_address;
  logic        mem_rd;
  logic [7:0]  mem_data_in;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready;
  logic        busy;
  logic        done;
  logic [3:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] rd_q[$];
  logic [7:0]  mem [logic [31:0]];

  srec_dump dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_address (base_address),
    .length       (length),
    .mem_address  (mem_address),
    .mem_rd       (mem_rd),
    .mem_data_in  (mem_data_in),
    .char_out     (char_out),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model and monitors ----------------
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    if (mem_rd) begin
      rd_q.push_back(mem_address);
      mem_data_in <= mem_byte(mem_address);
    end else begin
      mem_data_in <= 8'hEE;
    end
    if (!reset && char_valid && char_ready) got_q.push_back(char_out);
    if (!reset && done) done_cnt++;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // ---------------- scoreboard helpers / reference model ----------------
  function automatic logic [7:0] hexch(input logic [3:0] n);
    string hx;
    hx = "0123456789ABCDEF";
    return hx[n];
  endfunction

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(hexch(b[7:4]));
    exp_q.push_back(hexch(b[3:0]));
  endtask

  task automatic push_hdr();
`ifdef SREC_HEADER_EN
    push_str("S0030000FC\n");
`endif
  endtask

  task automatic model_dump(input logic [31:0] base, input int len);
    int off;
    int n;
    logic [31:0] a;
    logic [7:0] sum;
    logic [7:0] b;
    push_hdr();
    off = 0;
    while (off < len) begin
      n = (len - off > 16) ? 16 : len - off;
      a = base + 32'(off);
      sum = 8'(n + 5);
      push_str("S3");
      push_byte(8'(n + 5));
      for (int k = 0; k < 4; k++) begin
        b = 8'(a >> (24 - 8 * k));
        push_byte(b);
        sum += b;
      end
      for (int k = 0; k < n; k++) begin
        b = mem_byte(a + 32'(k));
        push_byte(b);
        sum += b;
      end
      push_byte(~sum);
      push_str("\n");
      off += n;
    end
    push_str("S705");
    sum = 8'h05;
    for (int k = 0; k < 4; k++) begin
      b = 8'(base >> (24 - 8 * k));
      push_byte(b);
      sum += b;
    end
    push_byte(~sum);
    push_str("\n");
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_nchars"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s_char%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_dump(input logic [31:0] base, input logic [15:0] len,
                          input int stall_at, input bit rand_ready,
                          input bit poke_start, input int budget);
    int cyc;
    bit stalled;
    logic [7:0] held;
    got_q.delete();
    rd_q.delete();
    done_cnt = 0;
    @(negedge clk);
    base_address = base;
    length       = len;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    // Inputs change after the start edge; the latched values must be used.
    base_address = 32'hA5A5_5A5A;
    length       = 16'hFFFF;
    check("busy_after_start", 32'(busy), 32'd1);
    cyc = 0;
    stalled = 1'b0;
    while (done_cnt == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = poke_start && (cyc == 20);
      if (rand_ready) char_ready = 1'($urandom_range(0, 1));
      if (!stalled && stall_at >= 0 && char_valid && got_q.size() >= stall_at) begin
        stalled = 1'b1;
        held = char_out;
        char_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          cyc++;
          check("stall_valid", 32'(char_valid), 32'd1);
          check("stall_char", 32'(char_out), 32'(held));
        end
        char_ready = 1'b1;
      end
    end
    start = 1'b0;
    char_ready = 1'b1;
    check("done_seen", 32'(done_cnt), 32'd1);
    @(negedge clk);
    check("done_low_after", 32'(done), 32'd0);
    check("busy_low_after", 32'(busy), 32'd0);
    check("idle_after", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    check("done_once", 32'(done_cnt), 32'd1);
    check("rd_count", 32'(rd_q.size()), 32'(len));
    for (int i = 0; i < rd_q.size(); i++)
      check($sformatf("rd_addr%0d", i), rd_q[i], base + 32'(i));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int n_before;
    int first_len;
    reset        = 1'b1;
    start        = 1'b0;
    base_address = '0;
    length       = '0;
    char_ready   = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_char_valid", 32'(char_valid), 32'd0);
    check("rst_char_out", 32'(char_out), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);

    // Three-byte dump at 0x10
    mem[32'h10] = 8'h01;
    mem[32'h11] = 8'h02;
    mem[32'h12] = 8'h03;
    exp_q.delete();
    push_hdr();
    push_str("S30800000010010203E1\n");
    push_str("S70500000010EA\n");
    run_dump(32'h10, 16'd3, -1, 1'b0, 1'b0, 3000);
    compare_stream("three_bytes");

    // Zero length: terminator only, no reads
    exp_q.delete();
    push_hdr();
    push_str("S70500000000FA\n");
    run_dump(32'h0, 16'd0, -1, 1'b0, 1'b0, 3000);
    compare_stream("zero_len");

    // 17 bytes at 0x100: full record plus one-byte record; a start mid-dump is ignored
    exp_q.delete();
    model_dump(32'h100, 17);
    run_dump(32'h100, 16'd17, -1, 1'b0, 1'b1, 6000);
    compare_stream("len17");
    check("len17_count1_hi", 32'(got_q[2]), 32'("1"));
    check("len17_count1_lo", 32'(got_q[3]), 32'("5"));

    // Sink stalls five cycles mid-record
    exp_q.delete();
    model_dump(32'h40, 5);
    run_dump(32'h40, 16'd5, 12, 1'b0, 1'b0, 3000);
    compare_stream("stall");

    // Address range crossing 0xFFFFFFFF
    exp_q.delete();
    model_dump(32'hFFFF_FFF8, 20);
    run_dump(32'hFFFF_FFF8, 16'd20, -1, 1'b0, 1'b0, 8000);
    compare_stream("wrap");

    // Randomly toggling char_ready
    exp_q.delete();
    model_dump(32'h1234_5670, 33);
    run_dump(32'h1234_5670, 16'd33, -1, 1'b1, 1'b0, 20000);
    compare_stream("rand_ready");

    // Reset during DATA of the second record
    got_q.delete();
    first_len = 47;
`ifdef SREC_HEADER_EN
    first_len += 11;
`endif
    @(negedge clk);
    base_address = 32'h200;
    length       = 16'd20;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(dbg_state == ST_DATA && got_q.size() > first_len) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_rec2_data", 32'(cyc < 4000), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_char_valid", 32'(char_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("midrst_mem_rd", 32'(mem_rd), 32'd0);
    reset = 1'b0;
    n_before = got_q.size();
    repeat (4) @(negedge clk);
    check("midrst_no_chars", 32'(got_q.size()), 32'(n_before));
    exp_q.delete();
    push_hdr();
    push_str("S30800000010010203E1\n");
    push_str("S70500000010EA\n");
    run_dump(32'h10, 16'd3, -1, 1'b0, 1'b0, 3000);
    compare_stream("after_reset");

`ifdef SREC_HEADER_EN
    // Header record ahead of a single-byte dump
    mem[32'h0] = 8'hAA;
    exp_q.delete();
    push_str("S0030000FC\n");
    push_str("S30600000000AA4F\n");
    push_str("S70500000000FA\n");
    run_dump(32'h0, 16'd1, -1, 1'b0, 1'b0, 3000);
    compare_stream("header");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/srec_dump.md
SREC_DUMP -- requirements
Module: srec_dump

Interface
REQ-001 The module SHALL have one clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a dump
- base_address  in  32  first memory byte address
- length  in  16  number of bytes to dump
- mem_address  out  32  byte read address
- mem_rd  out  1  read strobe, one cycle per byte
- mem_data_in  in  8  read data, valid the cycle after mem_rd
- char_out  out  8  ASCII character
- char_valid  out  1  char_out valid
- char_ready  in  1  sink accepts char_out
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse after the final newline is accepted

Function
REQ-003 start SHALL be sampled only in IDLE; base_address and length are latched on that edge; start while busy SHALL be ignored.
REQ-004 Data SHALL be emitted as S3 records of at most 16 data bytes, in ascending address order; the last record carries the remainder of length mod 16 (when nonzero).
REQ-005 Record format: 'S', '3', count (2 hex), address (8 hex), data (2 hex per byte), checksum (2 hex), 0x0A.
  - count = N+5, where N is the number of data bytes in the record.
  - checksum = ones' complement of the low byte of the sum of the count, the 4 address bytes and the data bytes.
REQ-006 Hex digits SHALL be upper-case ASCII (0x30-0x39, 0x41-0x46), high nibble first.
REQ-007 After the data records, one S7 terminator record SHALL be emitted with count 05, address = base_address, checksum per REQ-005, then 0x0A.
REQ-008 length = 0 SHALL emit only the S7 record (and the S0 record if configured).
REQ-009 The character handshake SHALL follow these rules:
  - A character transfers on a rising edge with char_valid and char_ready both high.
  - While char_valid is high and char_ready is low, char_out SHALL be held stable.
  - char_valid SHALL NOT drop until the transfer occurs.
REQ-010 FSM states SHALL be IDLE, HDR, REC_S, REC_T, COUNT, ADDR, FETCH, WAIT, DATA, CSUM, EOL, TERM, DONE.
  - IDLE->HDR (macro on) or IDLE->REC_S on start.
  - Within a data record: REC_S->REC_T->COUNT->ADDR, then FETCH->WAIT->DATA repeated per byte, then CSUM->EOL.
  - EOL->REC_S while bytes remain; otherwise EOL->TERM.
  - TERM emits the S7 record, then goes to DONE; DONE->IDLE after one cycle.
REQ-011 Each data byte SHALL be fetched by asserting mem_rd for exactly one cycle in FETCH, with mem_address = base_address + byte offset.
  - mem_data_in is captured in WAIT.
  - No more than one read is outstanding.
REQ-012 mem_address SHALL wrap modulo 2^32; a record whose address range crosses 0xFFFFFFFF SHALL still carry at most 16 bytes, and its data SHALL continue from 0x00000000.
REQ-013 The checksum accumulator SHALL be 8 bits wide, cleared at REC_S, and accumulate modulo 256.
REQ-014 busy SHALL be high from the edge after start until DONE is reached; done SHALL pulse high for one cycle in DONE.
REQ-015 mem_rd SHALL be low outside FETCH; char_valid SHALL be low in IDLE, FETCH, WAIT and DONE.

Reset
REQ-016 When reset is high, the FSM SHALL go to IDLE and the outputs SHALL be:
  - char_valid=0, char_out=0x00
  - mem_rd=0, mem_address=0
  - busy=0, done=0
REQ-017 Reset mid-dump SHALL abandon the record without emitting further characters; any pending character is dropped.
REQ-018 reset SHALL take priority over start in the same cycle.

Configuration
REQ-019 When macro SREC_HEADER_EN is defined, the record "S0030000FC" followed by 0x0A SHALL be emitted before the first data record of every dump.
REQ-020 When SREC_HEADER_EN is not defined, the HDR state and its logic SHALL be absent, and the first character of a dump SHALL be 'S' of the first S3 record.

Verification
REQ-021 base_address=0x00000010, length=3, memory 01 02 03, char_ready=1 -> "S30800000010010203E1\n" then "S70500000010EA\n", then done pulse.
REQ-022 base_address=0, length=0 -> only "S70500000000FA\n"; no mem_rd asserted.
REQ-023 base_address=0x100, length=17 -> a 16-byte record at 0x00000100 (count 15), a 1-byte record at 0x00000110 (count 06), then S7; the record checksums are checked against a reference model.
REQ-024 char_ready held low 5 cycles mid-record -> char_out and char_valid stable throughout; no character lost or duplicated.
REQ-025 reset asserted during DATA of the second record -> the next cycle shows char_valid=0, busy=0, IDLE state; a new start produces a complete, correct dump.
REQ-026 With SREC_HEADER_EN defined, length=1 at address 0 with data 0xAA -> "S0030000FC\n" then "S30600000000AA4F\n" then "S70500000000FA\n".
